// File: rtl/alu_rr_arbiter_pkg.sv
// Shared ALU op codes, response-buffer state encoding and the index-width helper
// used by the round-robin ALU sharing block.
package alu_rr_arbiter_pkg;

    localparam int unsigned ALU_OP_WIDTH = 4;

    typedef enum logic [ALU_OP_WIDTH-1:0] {
        ALU_OP_ADD  = 4'd0,
        ALU_OP_SUB  = 4'd1,
        ALU_OP_SLL  = 4'd2,
        ALU_OP_SLT  = 4'd3,
        ALU_OP_SLTU = 4'd4,
        ALU_OP_XOR  = 4'd5,
        ALU_OP_SRL  = 4'd6,
        ALU_OP_SRA  = 4'd7,
        ALU_OP_OR   = 4'd8,
        ALU_OP_AND  = 4'd9
    } alu_op_e;

    typedef enum logic {
        RSP_EMPTY = 1'b0,
        RSP_FULL  = 1'b1
    } rsp_state_e;

    // Index width for n items; never below 1 so a 1-bit index always exists.
    function automatic int unsigned clogb2(input int unsigned value);
        int unsigned r;
        r = 0;
        for (int unsigned v = value - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/alu_rr_arbiter_alu.sv
// Combinational integer ALU shared by all requesters of alu_rr_arbiter.
module alu
    import alu_rr_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [ALU_OP_WIDTH-1:0] i_op,
    input  logic [WIDTH-1:0]        i_a,
    input  logic [WIDTH-1:0]        i_b,
    output logic [WIDTH-1:0]        o_result
);

    localparam int unsigned SHW = $clog2(WIDTH);

    logic [SHW-1:0] shamt;

    assign shamt = i_b[SHW-1:0];

    always_comb begin
        o_result = '0;
        case (alu_op_e'(i_op))
            ALU_OP_ADD:  o_result = i_a + i_b;
            ALU_OP_SUB:  o_result = i_a - i_b;
            ALU_OP_SLL:  o_result = i_a << shamt;
            ALU_OP_SLT:  o_result = {{(WIDTH-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
            ALU_OP_SLTU: o_result = {{(WIDTH-1){1'b0}}, (i_a < i_b)};
            ALU_OP_XOR:  o_result = i_a ^ i_b;
            ALU_OP_SRL:  o_result = i_a >> shamt;
            ALU_OP_SRA:  o_result = $signed(i_a) >>> shamt;
            ALU_OP_OR:   o_result = i_a | i_b;
            ALU_OP_AND:  o_result = i_a & i_b;
            default:     o_result = '0;
        endcase
    end

endmodule

// File: rtl/alu_rr_arbiter_rr.sv
// Round-robin arbiter: first requester at or after ptr (with wrap) wins.
// gnt is one-hot only when en is high; gnt_idx is valid whenever any req is set.
module rr_arbiter
    import alu_rr_arbiter_pkg::*;
#(
    parameter int unsigned N = 4,
    localparam int unsigned IDX_W = clogb2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    input  logic             en,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx
);

    logic             found;
    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] idx;

    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        gnt     = '0;
        sum     = '0;
        idx     = '0;
        for (int unsigned i = 0; i < N; i++) begin
            sum = {1'b0, ptr} + (IDX_W+1)'(i);
            if (sum >= (IDX_W+1)'(N)) begin
                sum = sum - (IDX_W+1)'(N);
            end
            idx = sum[IDX_W-1:0];
            if (!found && req[idx]) begin
                found   = 1'b1;
                gnt_idx = idx;
            end
        end
        if (found && en) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/alu_rr_arbiter.sv
// Shares one ALU between NUM_REQ requesters with round-robin grant and a
// single-entry, requester-tagged response buffer (1 op/cycle throughput).
module alu_rr_arbiter
    import alu_rr_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned NUM_REQ = 4,
    localparam int unsigned ID_W   = clogb2(NUM_REQ)
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic [NUM_REQ-1:0]              i_req_valid,
    output logic [NUM_REQ-1:0]              o_req_ready,
    input  logic [NUM_REQ*ALU_OP_WIDTH-1:0] i_req_op,
    input  logic [NUM_REQ*WIDTH-1:0]        i_req_src1,
    input  logic [NUM_REQ*WIDTH-1:0]        i_req_src2,
    output logic                            o_rsp_valid,
    input  logic                            i_rsp_ready,
    output logic [ID_W-1:0]                 o_rsp_id,
    output logic [WIDTH-1:0]                o_rsp_data
);

    rsp_state_e            state_q, state_d;
    logic [ID_W-1:0]       ptr_q, ptr_d;
    logic [ID_W-1:0]       rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0]      rsp_data_q, rsp_data_d;

    logic                  can_accept;
    logic                  accept;
    logic                  drain;
    logic [NUM_REQ-1:0]    gnt;
    logic [ID_W-1:0]       gnt_idx;
    logic [ALU_OP_WIDTH-1:0] sel_op;
    logic [WIDTH-1:0]      sel_a;
    logic [WIDTH-1:0]      sel_b;
    logic [WIDTH-1:0]      alu_result;

    assign o_rsp_valid = (state_q == RSP_FULL);
    assign o_rsp_id    = rsp_id_q;
    assign o_rsp_data  = rsp_data_q;

    // Reset gates acceptance so no request is granted while i_rst is high.
    assign can_accept  = !i_rst && (!o_rsp_valid || i_rsp_ready);
    assign drain       = o_rsp_valid && i_rsp_ready;
    assign accept      = |gnt;
    assign o_req_ready = gnt;

    rr_arbiter #(
        .N (NUM_REQ)
    ) u_rr_arbiter (
        .req     (i_req_valid),
        .ptr     (ptr_q),
        .en      (can_accept),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    always_comb begin
        sel_op = '0;
        sel_a  = '0;
        sel_b  = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (gnt_idx == ID_W'(k)) begin
                sel_op = i_req_op[k*ALU_OP_WIDTH +: ALU_OP_WIDTH];
                sel_a  = i_req_src1[k*WIDTH +: WIDTH];
                sel_b  = i_req_src2[k*WIDTH +: WIDTH];
            end
        end
    end

    alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .i_op     (sel_op),
        .i_a      (sel_a),
        .i_b      (sel_b),
        .o_result (alu_result)
    );

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        rsp_id_d   = rsp_id_q;
        rsp_data_d = rsp_data_q;
        if (accept) begin
            state_d    = RSP_FULL;
            rsp_id_d   = gnt_idx;
            rsp_data_d = alu_result;
            ptr_d      = (gnt_idx == ID_W'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1;
        end else if (drain) begin
            state_d    = RSP_EMPTY;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= RSP_EMPTY;
            ptr_q      <= '0;
            rsp_id_q   <= '0;
            rsp_data_q <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            rsp_id_q   <= rsp_id_d;
            rsp_data_q <= rsp_data_d;
        end
    end

endmodule
